// File: rtl/matmul_pkg.sv
// matmul_pkg: shared definitions for the runtime-dimensioned matmul tile.
//   state_t    - sequencer FSM states (IDLE, CHECK, RUN, FIN)
//   dim_w      - width needed to hold a dimension in 0..max_dim
//   rm_index   - row-major flat index: row * ncols + col
//   dims_legal - dimension legality test performed in CHECK
package matmul_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        RUN   = 2'd2,
        FIN   = 2'd3
    } state_t;

    function automatic int dim_w(input int max_dim);
        return $clog2(max_dim + 1);
    endfunction

    function automatic int rm_index(input int row, input int col, input int ncols);
        return row * ncols + col;
    endfunction

    // Every dimension must be 1..max_dim and each of the three matrices
    // must fit in one BRAM of 2**addr_w words.
    function automatic bit dims_legal(input int m, input int k, input int n,
                                      input int max_dim, input int addr_w);
        int depth;
        depth = 1 << addr_w;
        return (m > 0) && (k > 0) && (n > 0) &&
               (m <= max_dim) && (k <= max_dim) && (n <= max_dim) &&
               (m * k <= depth) && (k * n <= depth) && (m * n <= depth);
    endfunction

endpackage

// File: rtl/bram.sv
// bram: simple dual-port block RAM, one write port and one registered read
// port (1-cycle latency). A read issued the cycle after a write to the same
// address sees the new data. Contents are never reset.
//   clk                          - clock
//   wr_en / wr_addr / wr_data    - write port
//   rd_addr / rd_data            - read port, rd_data valid one cycle later
module bram #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/matmul_seq.sv
// matmul_seq: sequencing engine. Holds the FSM, the i/j/k counters, the
// product-valid pipeline bit and the accumulator.
//   start/dim_*/acc_mode  - job request, sampled only in IDLE
//   x/y/z_rd_addr, *_rd_data - BRAM read ports (1-cycle latency)
//   z_wr_*                - Z BRAM write port
//   busy/done/error       - status; fsm_state exposes the FSM for debug
// Protocol: start is a one-cycle request with no ready; it is accepted only
// when the FSM is IDLE and no error pulse is showing, otherwise dropped.
// Completion is a one-cycle done pulse, rejection a one-cycle error pulse.
// Each Z element takes K+2 cycles: K read-issue cycles (cnt 0..K-1), one
// drain cycle for the last product (cnt K), one write cycle (cnt K+1).
module matmul_seq
    import matmul_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 32,
    parameter int MAX_DIM = 32,
    parameter int DIM_W   = dim_w(MAX_DIM)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DIM_W-1:0]  dim_m,
    input  logic [DIM_W-1:0]  dim_k,
    input  logic [DIM_W-1:0]  dim_n,
    input  logic              acc_mode,
    input  logic [DATA_W-1:0] x_rd_data,
    input  logic [DATA_W-1:0] y_rd_data,
    input  logic [DATA_W-1:0] z_rd_data,
    output logic [ADDR_W-1:0] x_rd_addr,
    output logic [ADDR_W-1:0] y_rd_addr,
    output logic [ADDR_W-1:0] z_rd_addr,
    output logic              z_wr_en,
    output logic [ADDR_W-1:0] z_wr_addr,
    output logic [DATA_W-1:0] z_wr_data,
    output logic              busy,
    output logic              done,
    output logic              error,
    output state_t            fsm_state
);

    // One extra bit so the counter can reach K+1 when K == MAX_DIM.
    localparam int CNT_W = DIM_W + 1;

    state_t            state_q, state_d;
    logic [DIM_W-1:0]  m_q, k_q, n_q, i_q, j_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              acc_mode_q, prod_valid_q, first_q, error_q;
    logic [DATA_W-1:0] acc_q;

    logic              accept, dims_ok, issue, write_cyc, last_col, last_elem;
    logic [DATA_W-1:0] prod_lo, seed;

    assign accept    = (state_q == IDLE) && start && !error_q;
    assign dims_ok   = dims_legal(int'(m_q), int'(k_q), int'(n_q), MAX_DIM, ADDR_W);
    assign issue     = (state_q == RUN) && (cnt_q < CNT_W'(k_q));
    assign write_cyc = (state_q == RUN) && (cnt_q == CNT_W'(k_q) + CNT_W'(1));
    assign last_col  = (j_q == n_q - DIM_W'(1));
    assign last_elem = last_col && (i_q == m_q - DIM_W'(1));

    // Addresses outside the issue window are harmless dummy reads.
    assign x_rd_addr = ADDR_W'(rm_index(int'(i_q), int'(cnt_q), int'(k_q)));
    assign y_rd_addr = ADDR_W'(rm_index(int'(cnt_q), int'(j_q), int'(n_q)));
    // Z is read (accumulate seed) at cnt 0 and written at cnt K+1, same address.
    assign z_rd_addr = ADDR_W'(rm_index(int'(i_q), int'(j_q), int'(n_q)));
    assign z_wr_addr = z_rd_addr;
    assign z_wr_data = acc_q;

    // Low W bits of the product are identical for signed and unsigned operands.
    assign prod_lo = x_rd_data * y_rd_data;
    assign seed    = acc_mode_q ? z_rd_data : '0;

    assign error     = error_q;
    assign fsm_state = state_q;

    always_comb begin
        state_d = state_q;
        busy    = (state_q != IDLE);
        done    = 1'b0;
        z_wr_en = 1'b0;
        case (state_q)
            IDLE:    if (accept) state_d = CHECK;
            CHECK:   state_d = dims_ok ? RUN : IDLE;
            RUN: begin
                z_wr_en = write_cyc;
                if (write_cyc && last_elem) state_d = FIN;
            end
            FIN: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            m_q          <= '0;
            k_q          <= '0;
            n_q          <= '0;
            acc_mode_q   <= 1'b0;
            i_q          <= '0;
            j_q          <= '0;
            cnt_q        <= '0;
            prod_valid_q <= 1'b0;
            first_q      <= 1'b0;
            acc_q        <= '0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            // Registered so the pulse lands in the cycle after CHECK.
            error_q      <= (state_q == CHECK) && !dims_ok;
            prod_valid_q <= issue;
            first_q      <= issue && (cnt_q == '0);

            if (accept) begin
                m_q        <= dim_m;
                k_q        <= dim_k;
                n_q        <= dim_n;
                acc_mode_q <= acc_mode;
            end

            if (state_q == CHECK) begin
                i_q   <= '0;
                j_q   <= '0;
                cnt_q <= '0;
            end else if (state_q == RUN) begin
                if (write_cyc) begin
                    cnt_q <= '0;
                    if (last_col) begin
                        j_q <= '0;
                        i_q <= i_q + DIM_W'(1);
                    end else begin
                        j_q <= j_q + DIM_W'(1);
                    end
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end

            // The first product of an element replaces the sum with the seed.
            if (prod_valid_q) begin
                acc_q <= (first_q ? seed : acc_q) + prod_lo;
            end
        end
    end

endmodule

// File: rtl/matmul_tile_top.sv
// matmul_tile_top: X, Y, Z BRAMs plus the matmul_seq engine computing
// Z = X*Y or Z += X*Y for runtime M x K by K x N shapes (row-major layout).
//   clk, rst_n                 - clock, async active-low reset
//   start, dim_m/k/n, acc_mode - job request
//   x_din/x_wr_addr/x_wr_en    - host write port, X BRAM
//   y_din/y_wr_addr/y_wr_en    - host write port, Y BRAM
//   z_rd_addr / z_dout         - host read port, Z BRAM (1-cycle latency)
//   busy, done, error          - status
//   fsm_state                  - engine FSM state for debug
module matmul_tile_top
    import matmul_pkg::*;
#(
    parameter int BRAM_ADDR_WIDTH = 10,
    parameter int BRAM_DATA_WIDTH = 32,
    parameter int MAX_DIM         = 32,
    parameter int DIM_W           = dim_w(MAX_DIM)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [DIM_W-1:0]           dim_m,
    input  logic [DIM_W-1:0]           dim_k,
    input  logic [DIM_W-1:0]           dim_n,
    input  logic                       acc_mode,
    input  logic [BRAM_DATA_WIDTH-1:0] x_din,
    input  logic [BRAM_ADDR_WIDTH-1:0] x_wr_addr,
    input  logic                       x_wr_en,
    input  logic [BRAM_DATA_WIDTH-1:0] y_din,
    input  logic [BRAM_ADDR_WIDTH-1:0] y_wr_addr,
    input  logic                       y_wr_en,
    input  logic [BRAM_ADDR_WIDTH-1:0] z_rd_addr,
    output logic [BRAM_DATA_WIDTH-1:0] z_dout,
    output logic                       busy,
    output logic                       done,
    output logic                       error,
    output state_t                     fsm_state
);

    localparam int AW = BRAM_ADDR_WIDTH;
    localparam int DW = BRAM_DATA_WIDTH;

    logic [AW-1:0] x_rd_addr, y_rd_addr, eng_z_rd_addr, z_rd_addr_mux, z_wr_addr;
    logic [DW-1:0] x_rd_data, y_rd_data, z_rd_data, z_wr_data;
    logic          z_wr_en;

    // The engine owns the Z read port for the whole job.
    assign z_rd_addr_mux = busy ? eng_z_rd_addr : z_rd_addr;
    assign z_dout        = z_rd_data;

    bram #(.ADDR_W(AW), .DATA_W(DW)) u_x_bram (
        .clk     (clk),
        .wr_en   (x_wr_en),
        .wr_addr (x_wr_addr),
        .wr_data (x_din),
        .rd_addr (x_rd_addr),
        .rd_data (x_rd_data)
    );

    bram #(.ADDR_W(AW), .DATA_W(DW)) u_y_bram (
        .clk     (clk),
        .wr_en   (y_wr_en),
        .wr_addr (y_wr_addr),
        .wr_data (y_din),
        .rd_addr (y_rd_addr),
        .rd_data (y_rd_data)
    );

    bram #(.ADDR_W(AW), .DATA_W(DW)) u_z_bram (
        .clk     (clk),
        .wr_en   (z_wr_en),
        .wr_addr (z_wr_addr),
        .wr_data (z_wr_data),
        .rd_addr (z_rd_addr_mux),
        .rd_data (z_rd_data)
    );

    matmul_seq #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .MAX_DIM (MAX_DIM),
        .DIM_W   (DIM_W)
    ) u_seq (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dim_m     (dim_m),
        .dim_k     (dim_k),
        .dim_n     (dim_n),
        .acc_mode  (acc_mode),
        .x_rd_data (x_rd_data),
        .y_rd_data (y_rd_data),
        .z_rd_data (z_rd_data),
        .x_rd_addr (x_rd_addr),
        .y_rd_addr (y_rd_addr),
        .z_rd_addr (eng_z_rd_addr),
        .z_wr_en   (z_wr_en),
        .z_wr_addr (z_wr_addr),
        .z_wr_data (z_wr_data),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .fsm_state (fsm_state)
    );

endmodule

// File: tb/tb_matmul_tile_top.sv
module tb_matmul_tile_top;
  import matmul_pkg::*;

  localparam int AW    = 10;
  localparam int DW    = 32;
  localparam int MAXD  = 32;
  localparam int DIMW  = dim_w(MAXD);
  localparam int DEPTH = 1 << AW;

  // ---------------- clock / reset / DUT ----------------
  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [DIMW-1:0] dim_m = '0, dim_k = '0, dim_n = '0;
  logic            acc_mode = 1'b0;
  logic [DW-1:0]   x_din = '0, y_din = '0;
  logic [AW-1:0]   x_wr_addr = '0, y_wr_addr = '0, z_rd_addr = '0;
  logic            x_wr_en = 1'b0, y_wr_en = 1'b0;
  logic [DW-1:0]   z_dout;
  logic            busy, done, error;
  state_t          fsm_state;

  always #5 clk = ~clk;

  matmul_tile_top #(
    .BRAM_ADDR_WIDTH(AW), .BRAM_DATA_WIDTH(DW), .MAX_DIM(MAXD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .dim_m(dim_m), .dim_k(dim_k), .dim_n(dim_n), .acc_mode(acc_mode),
    .x_din(x_din), .x_wr_addr(x_wr_addr), .x_wr_en(x_wr_en),
    .y_din(y_din), .y_wr_addr(y_wr_addr), .y_wr_en(y_wr_en),
    .z_rd_addr(z_rd_addr), .z_dout(z_dout),
    .busy(busy), .done(done), .error(error), .fsm_state(fsm_state)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard / reference model ----------------
  int            n_checks = 0;
  int            n_fail = 0;
  logic [DW-1:0] x_m [DEPTH];
  logic [DW-1:0] y_m [DEPTH];
  logic [DW-1:0] z_m [DEPTH];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] base [4];

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
    end
  endtask

  // Plain matrix product over the model memories, 32-bit wrapping sums.
  task automatic golden(input int m, input int k, input int n, input bit acc);
    logic [DW-1:0] s;
    for (int i = 0; i < m; i++) begin
      for (int j = 0; j < n; j++) begin
        s = acc ? z_m[i*n + j] : '0;
        for (int kk = 0; kk < k; kk++) s = s + x_m[i*k + kk] * y_m[kk*n + j];
        z_m[i*n + j] = s;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put_x(input int a, input logic [DW-1:0] d);
    x_m[a] = d;
    x_wr_addr = AW'(a); x_din = d; x_wr_en = 1'b1;
    tick();
    x_wr_en = 1'b0;
  endtask

  task automatic put_y(input int a, input logic [DW-1:0] d);
    y_m[a] = d;
    y_wr_addr = AW'(a); y_din = d; y_wr_en = 1'b1;
    tick();
    y_wr_en = 1'b0;
  endtask

  task automatic rand_xy(input int m, input int k, input int n, input bit full);
    for (int a = 0; a < m*k; a++) put_x(a, full ? DW'($urandom()) : DW'(int'($urandom_range(0, 2000)) - 1000));
    for (int a = 0; a < k*n; a++) put_y(a, full ? DW'($urandom()) : DW'(int'($urandom_range(0, 2000)) - 1000));
  endtask

  task automatic read_z(input int a, output logic [DW-1:0] d);
    z_rd_addr = AW'(a);
    tick();
    d = z_dout;
  endtask

  // Pops one expected value per address in lo..hi and compares Z.
  task automatic drain_z(input int lo, input int hi, input string tag);
    logic [DW-1:0] d;
    for (int a = lo; a <= hi; a++) begin
      read_z(a, d);
      check($sformatf("%s_z%0d", tag, a), d, exp_q.pop_front());
    end
  endtask

  task automatic verify_z(input int lo, input int hi, input string tag);
    for (int a = lo; a <= hi; a++) exp_q.push_back(z_m[a]);
    drain_z(lo, hi, tag);
  endtask

  // Start is high in cycle 0; every later cycle is observed #1 after its edge.
  task automatic run_job(input int m, input int k, input int n, input bit acc,
                         input bit exp_err, input int inject_at, input string tag);
    int exp_done, last_c, done_cyc, err_cyc, busy_cnt, done_cnt, err_cnt;
    exp_done = 2 + m*n*(k+2);
    last_c   = exp_err ? 3 : exp_done + 1;
    done_cyc = -1; err_cyc = -1;
    busy_cnt = 0; done_cnt = 0; err_cnt = 0;
    dim_m = DIMW'(m); dim_k = DIMW'(k); dim_n = DIMW'(n);
    acc_mode = acc;
    start = 1'b1;
    for (int c = 1; c <= last_c; c++) begin
      tick();
      if (c == inject_at) begin
        start = 1'b1;
        dim_m = DIMW'(1); dim_k = DIMW'(1); dim_n = DIMW'(1);
        acc_mode = ~acc;
      end else if (c == 1 || c == inject_at + 1) begin
        start = 1'b0;
      end
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (error === 1'b1) begin
        err_cnt++;
        if (err_cyc < 0) err_cyc = c;
      end
    end
    start = 1'b0;
    if (exp_err) begin
      check({tag, "_err_cycle"}, DW'(err_cyc), DW'(2));
      check({tag, "_err_pulses"}, DW'(err_cnt), DW'(1));
      check({tag, "_no_done"}, DW'(done_cnt), DW'(0));
      check({tag, "_busy_cycles"}, DW'(busy_cnt), DW'(1));
    end else begin
      check({tag, "_done_cycle"}, DW'(done_cyc), DW'(exp_done));
      check({tag, "_done_pulses"}, DW'(done_cnt), DW'(1));
      check({tag, "_busy_cycles"}, DW'(busy_cnt), DW'(exp_done));
      check({tag, "_no_error"}, DW'(err_cnt), DW'(0));
      golden(m, k, n, acc);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", DW'(busy), DW'(0));
    check("rst_done", DW'(done), DW'(0));
    check("rst_error", DW'(error), DW'(0));
    check("rst_state", DW'(fsm_state), DW'(IDLE));
    rst_n = 1'b1;
    tick();

    // 2x2x2, Y = identity
    put_x(0, 1); put_x(1, 2); put_x(2, 3); put_x(3, 4);
    put_y(0, 1); put_y(1, 0); put_y(2, 0); put_y(3, 1);
    run_job(2, 2, 2, 1'b0, 1'b0, 0, "a");
    exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3); exp_q.push_back(4);
    drain_z(0, 3, "a");

    // 8x8x8, X[i][k] = i+k, Y[k][j] = k-j
    for (int i = 0; i < 8; i++)
      for (int k = 0; k < 8; k++) put_x(i*8 + k, DW'(i + k));
    for (int k = 0; k < 8; k++)
      for (int j = 0; j < 8; j++) put_y(k*8 + j, DW'(k - j));
    run_job(8, 8, 8, 1'b0, 1'b0, 0, "b");
    verify_z(0, 63, "b");

    // 3x5x2 random signed; addresses 6..63 must keep the previous result
    rand_xy(3, 5, 2, 1'b0);
    run_job(3, 5, 2, 1'b0, 1'b0, 0, "c");
    verify_z(0, 63, "c");

    // accumulate twice on a full-range random product -> 3 * (X*Y)
    rand_xy(2, 3, 2, 1'b1);
    run_job(2, 3, 2, 1'b0, 1'b0, 0, "d0");
    for (int a = 0; a < 4; a++) base[a] = z_m[a];
    run_job(2, 3, 2, 1'b1, 1'b0, 0, "d1");
    run_job(2, 3, 2, 1'b1, 1'b0, 0, "d2");
    for (int a = 0; a < 4; a++) exp_q.push_back(base[a] * 3);
    drain_z(0, 3, "d3x");

    // 0x7FFFFFFF accumulated twice wraps
    put_x(0, 32'h7fff_ffff); put_y(0, 32'h1);
    run_job(1, 1, 1, 1'b0, 1'b0, 0, "w0");
    exp_q.push_back(32'h7fff_ffff);
    drain_z(0, 0, "w0");
    run_job(1, 1, 1, 1'b1, 1'b0, 0, "w1");
    exp_q.push_back(32'hffff_fffe);
    drain_z(0, 0, "w1");

    // rejected starts, then an immediate valid restart
    rand_xy(2, 2, 2, 1'b0);
    run_job(2, 0, 2, 1'b0, 1'b1, 0, "e_k0");
    run_job(MAXD + 1, 2, 2, 1'b0, 1'b1, 0, "e_mbig");
    run_job(2, 2, 2, 1'b0, 1'b0, 0, "e_restart");
    verify_z(0, 63, "e");

    // reset in the middle of a 4x4x4 run
    rand_xy(4, 4, 4, 1'b0);
    dim_m = DIMW'(4); dim_k = DIMW'(4); dim_n = DIMW'(4); acc_mode = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (30) tick();
    check("mid_busy", DW'(busy), DW'(1));
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", DW'(busy), DW'(0));
    check("mid_rst_done", DW'(done), DW'(0));
    check("mid_rst_state", DW'(fsm_state), DW'(IDLE));
    tick();
    rst_n = 1'b1;
    tick();
    // rerun with a start pulse injected while busy
    run_job(4, 4, 4, 1'b0, 1'b0, 10, "g");
    verify_z(0, 15, "g");
    repeat (3) tick();
    check("g_idle_after", DW'(busy), DW'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
